mem_io_bridge: RTL and testbench

Sits between the SLC-3 control unit/datapath and the external 16-bit SRAM. Converts the controller's active-low Mem_OE/Mem_WE strobes into SRAM read and write cycles with proper setup/hold, and returns read data to MDR with one-cycle latency. Decodes address 0xFFFF as memory-mapped I/O: switches on read, hex display register on write. Also holds the PAUSE LED register loaded by LD_LED.

---
 rtl/slc3_pkg.sv | 16 +
 rtl/mem_io_bridge_sync2.sv | 23 ++
 rtl/mem_io_bridge.sv | 148 ++++++++++++++
 tb/tb_mem_io_bridge.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_pkg.sv
// Shared types and constants for the SLC-3 memory/IO bridge.
package slc3_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_HOLD  = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    WR_END   = 3'd5
  } mem_io_state_t;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
  localparam int          SRAM_ADDR_W     = 20;

endpackage

// File: rtl/mem_io_bridge_sync2.sv
// Two-flop synchronizer with synchronous reset, used for the board switches.
module sync2 #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// SLC-3 bridge from control-unit Mem_OE/Mem_WE strobes to external SRAM cycles.
// Define MEM_IO_MAP_EN to decode IO_ADDR as switches (read) / hex display (write).
module mem_io_bridge
  import slc3_pkg::*;
#(
  parameter int          READ_WAIT = 0,
  parameter logic [15:0] IO_ADDR   = IO_ADDR_DEFAULT
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [15:0]            MAR,
  input  logic [15:0]            Data_from_CPU,
  input  logic                   Mem_OE,
  input  logic                   Mem_WE,
  input  logic                   LD_LED,
  input  logic [11:0]            IR,
  input  logic [15:0]            Switches,
  input  logic [15:0]            SRAM_Data_in,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic [15:0]            SRAM_Data_out,
  output logic                   SRAM_Drive,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N,
  output logic [15:0]            Data_to_CPU,
  output logic                   Rd_valid,
  output logic                   Ready,
  output logic [15:0]            HEX_Data,
  output logic [11:0]            LED,
  output mem_io_state_t          dbg_state
);

  // Handshake: a request is the active-low Mem_OE/Mem_WE level, sampled every
  // edge. Ready high means the bridge is idle or Data_to_CPU holds a read
  // (Rd_valid); a requester holding a strobe while Ready is low is stalled.

  localparam int CNT_W = $clog2(READ_WAIT + 2);

  mem_io_state_t    state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_inc_val;
  logic             cnt_clr, cnt_inc, capture, latch_wr, load_hex;
  logic             is_io;
  logic [15:0]      wr_data, sw_sync, rd_data;

`ifdef MEM_IO_MAP_EN
  logic [15:0] hex_q;

  assign is_io = (MAR == IO_ADDR);

  sync2 #(.W(16)) u_sw_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (Switches),
    .q     (sw_sync)
  );

  always_ff @(posedge Clk) begin
    if (Reset)         hex_q <= '0;
    else if (load_hex) hex_q <= Data_from_CPU;
  end

  assign HEX_Data = hex_q;
`else
  logic unused_io;

  assign is_io     = 1'b0;
  assign sw_sync   = '0;
  assign HEX_Data  = '0;
  assign unused_io = ^{Switches, IO_ADDR, load_hex};
`endif

  assign cnt_inc_val = cnt + 1'b1;
  assign rd_data     = is_io ? sw_sync : SRAM_Data_in;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Writes win over reads when both strobes are low in IDLE.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    capture   = 1'b0;
    latch_wr  = 1'b0;
    load_hex  = 1'b0;
    case (state)
      IDLE: begin
        if (!Mem_WE) begin
          latch_wr = 1'b1;
          if (is_io) begin
            load_hex  = 1'b1;
            state_nxt = WR_END;
          end else begin
            state_nxt = WR_PULSE;
          end
        end else if (!Mem_OE) begin
          cnt_clr = 1'b1;
          if (READ_WAIT == 0) begin
            capture   = 1'b1;
            state_nxt = RD_HOLD;
          end else begin
            state_nxt = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        cnt_inc = 1'b1;
        if (cnt_inc_val == READ_WAIT[CNT_W-1:0]) begin
          capture   = 1'b1;
          state_nxt = RD_HOLD;
        end
      end
      RD_HOLD:  if (Mem_OE) state_nxt = IDLE;
      WR_PULSE: state_nxt = WR_HOLD;
      WR_HOLD:  state_nxt = WR_END;
      WR_END:   if (Mem_WE) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt         <= '0;
      wr_data     <= '0;
      Data_to_CPU <= '0;
      LED         <= '0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt_inc_val;
      if (latch_wr) wr_data     <= Data_from_CPU;
      if (capture)  Data_to_CPU <= rd_data;
      if (LD_LED)   LED         <= IR;
    end
  end

  // Write strobe and drive decode from the state register only, so no glitches.
  assign SRAM_WE_N     = (state != WR_PULSE);
  assign SRAM_Drive    = (state == WR_PULSE) || (state == WR_HOLD);
  assign SRAM_OE_N     = Mem_OE | ~Mem_WE | is_io |
                         (state == WR_PULSE) | (state == WR_HOLD) | (state == WR_END);
  assign SRAM_ADDR     = {{(SRAM_ADDR_W-16){1'b0}}, MAR};
  assign SRAM_Data_out = wr_data;
  assign Rd_valid      = (state == RD_HOLD);
  assign Ready         = (state == IDLE) || (state == RD_HOLD);
  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: one READ_WAIT=0 instance (a) and one READ_WAIT=2 instance (b).
module tb_mem_io_bridge;
  import slc3_pkg::*;

`ifdef MEM_IO_MAP_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] MAR, Data_from_CPU, Switches;
  logic        Mem_OE, Mem_WE, LD_LED;
  logic [11:0] IR;

  logic [19:0]   addr_a, addr_b;
  logic [15:0]   din_a, din_b, dout_a, dout_b, cpu_a, cpu_b, hex_a, hex_b;
  logic          drv_a, drv_b, oe_n_a, oe_n_b, we_n_a, we_n_b;
  logic          rdv_a, rdv_b, rdy_a, rdy_b;
  logic [11:0]   led_a, led_b;
  mem_io_state_t dbg_a, dbg_b;

  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];
  logic        pre_en, pre_sel, ovr_en;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data, ovr_data;

  int n_assert = 0;
  int n_fail   = 0;
  int we_low_a = 0, drv_hi_a = 0, oe_low_a = 0, we_low_b = 0, oe_low_b = 0;
  int we_s, drv_s, oe_s;
  logic [15:0] exp_q[$];
  logic [15:0] exp;

  always #5 Clk = ~Clk;

  mem_io_bridge u_dut_a (
    .Clk(Clk), .Reset(Reset), .MAR(MAR), .Data_from_CPU(Data_from_CPU),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .LD_LED(LD_LED), .IR(IR),
    .Switches(Switches), .SRAM_Data_in(din_a), .SRAM_ADDR(addr_a),
    .SRAM_Data_out(dout_a), .SRAM_Drive(drv_a), .SRAM_OE_N(oe_n_a),
    .SRAM_WE_N(we_n_a), .Data_to_CPU(cpu_a), .Rd_valid(rdv_a), .Ready(rdy_a),
    .HEX_Data(hex_a), .LED(led_a), .dbg_state(dbg_a)
  );

  mem_io_bridge #(.READ_WAIT(2)) u_dut_b (
    .Clk(Clk), .Reset(Reset), .MAR(MAR), .Data_from_CPU(Data_from_CPU),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .LD_LED(LD_LED), .IR(IR),
    .Switches(Switches), .SRAM_Data_in(din_b), .SRAM_ADDR(addr_b),
    .SRAM_Data_out(dout_b), .SRAM_Drive(drv_b), .SRAM_OE_N(oe_n_b),
    .SRAM_WE_N(we_n_b), .Data_to_CPU(cpu_b), .Rd_valid(rdv_b), .Ready(rdy_b),
    .HEX_Data(hex_b), .LED(led_b), .dbg_state(dbg_b)
  );

  // SRAM models: asynchronous read, write on any edge where WE_N is low.
  assign din_a = ovr_en ? ovr_data : mem_a[addr_a[7:0]];
  assign din_b = mem_b[addr_b[7:0]];

  always @(posedge Clk) begin
    if (pre_en && !pre_sel) mem_a[pre_addr]    <= pre_data;
    else if (!we_n_a)       mem_a[addr_a[7:0]] <= dout_a;
  end

  always @(posedge Clk) begin
    if (pre_en && pre_sel) mem_b[pre_addr]    <= pre_data;
    else if (!we_n_b)      mem_b[addr_b[7:0]] <= dout_b;
  end

  always @(negedge Clk) begin
    if (!we_n_a) we_low_a++;
    if (drv_a)   drv_hi_a++;
    if (!oe_n_a) oe_low_a++;
    if (!we_n_b) we_low_b++;
    if (!oe_n_b) oe_low_b++;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic poke(input logic sel, input logic [7:0] a, input logic [15:0] d);
    pre_sel = sel; pre_addr = a; pre_data = d; pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  initial begin
    Reset = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1; MAR = '0; Data_from_CPU = '0;
    LD_LED = 1'b0; IR = '0; Switches = 16'h5A5A;
    pre_en = 1'b0; pre_sel = 1'b0; pre_addr = '0; pre_data = '0;
    ovr_en = 1'b0; ovr_data = '0;
    poke(1'b0, 8'h10, 16'h1234);
    poke(1'b1, 8'h40, 16'h4242);
    tick();

    // Reset state
    chk("rst_state", dbg_a, IDLE);
    chk("rst_cpu", cpu_a, 16'h0);
    chk("rst_rdv", rdv_a, 1'b0);
    chk("rst_ready", rdy_a, 1'b1);
    chk("rst_hex", hex_a, 16'h0);
    chk("rst_led", led_a, 12'h0);
    chk("rst_we_n", we_n_a, 1'b1);
    chk("rst_drive", drv_a, 1'b0);
    chk("rst_oe_n", oe_n_a, 1'b1);
    Reset = 1'b0;
    tick();

    // SRAM read, 2-cycle strobe
    exp_q.push_back(16'h1234);
    MAR = 16'h0010; Mem_OE = 1'b0; #1;
    chk("rd_addr", addr_a, 20'h00010);
    chk("rd_oe_n_c0", oe_n_a, 1'b0);
    chk("rd_rdv_c0", rdv_a, 1'b0);
    tick();
    chk("rd_oe_n_c1", oe_n_a, 1'b0);
    chk("rd_rdv_c1", rdv_a, 1'b1);
    exp = exp_q.pop_front();
    chk("rd_data", cpu_a, exp);
    ovr_data = 16'h9999; ovr_en = 1'b1;
    tick();
    Mem_OE = 1'b1; #1;
    chk("rd_no_recapture", cpu_a, 16'h1234);
    chk("rd_hold_rdv", rdv_a, 1'b1);
    chk("rd_oe_n_rel", oe_n_a, 1'b1);
    ovr_en = 1'b0;
    tick();
    chk("rd_done_rdv", rdv_a, 1'b0);
    tick(); tick(); tick();

    // SRAM write
    we_s = we_low_a; drv_s = drv_hi_a; oe_s = oe_low_a;
    MAR = 16'h0020; Data_from_CPU = 16'hBEEF; Mem_WE = 1'b0; #1;
    chk("wr_oe_n_c0", oe_n_a, 1'b1);
    tick();
    chk("wr_we_n_c1", we_n_a, 1'b0);
    chk("wr_drive_c1", drv_a, 1'b1);
    chk("wr_ready_c1", rdy_a, 1'b0);
    chk("wr_dout_c1", dout_a, 16'hBEEF);
    Data_from_CPU = 16'h0000;
    tick();
    Mem_WE = 1'b1; #1;
    chk("wr_we_n_c2", we_n_a, 1'b1);
    chk("wr_drive_c2", drv_a, 1'b1);
    chk("wr_dout_c2", dout_a, 16'hBEEF);
    tick();
    chk("wr_drive_c3", drv_a, 1'b0);
    tick();
    chk("wr_ready_end", rdy_a, 1'b1);
    chk("wr_we_cycles", 32'(we_low_a - we_s), 32'd1);
    chk("wr_drive_cycles", 32'(drv_hi_a - drv_s), 32'd2);
    chk("wr_oe_low_cycles", 32'(oe_low_a - oe_s), 32'd0);
    chk("wr_mem", mem_a[8'h20], 16'hBEEF);

    // I/O write to 0xFFFF
    we_s = we_low_a; drv_s = drv_hi_a;
    MAR = 16'hFFFF; Data_from_CPU = 16'h00A5; Mem_WE = 1'b0;
    tick();
    tick();
    Mem_WE = 1'b1;
    tick(); tick();
    chk("io_hex", hex_a, IO_EN ? 16'h00A5 : 16'h0000);
    chk("io_we_cycles", 32'(we_low_a - we_s), IO_EN ? 32'd0 : 32'd1);
    chk("io_drive_cycles", 32'(drv_hi_a - drv_s), IO_EN ? 32'd0 : 32'd2);

    // I/O read of switches (without the map, 0xFFFF is plain SRAM)
    exp_q.push_back(IO_EN ? 16'h5A5A : 16'h00A5);
    Mem_OE = 1'b0; #1;
    chk("io_rd_oe_n", oe_n_a, IO_EN ? 1'b1 : 1'b0);
    tick();
    exp = exp_q.pop_front();
    chk("io_rd_data", cpu_a, exp);
    tick();
    Mem_OE = 1'b1;
    tick(); tick(); tick();

    // LED latch
    LD_LED = 1'b1; IR = 12'hABC;
    tick();
    LD_LED = 1'b0; IR = 12'h123; #1;
    chk("led_load", led_a, 12'hABC);
    tick();
    chk("led_hold", led_a, 12'hABC);

    // Reset in the middle of a write
    MAR = 16'h0030; Data_from_CPU = 16'h1111; Mem_WE = 1'b0;
    tick();
    chk("rstw_we_n_pre", we_n_a, 1'b0);
    Reset = 1'b1;
    tick();
    chk("rstw_we_n", we_n_a, 1'b1);
    chk("rstw_drive", drv_a, 1'b0);
    chk("rstw_hex", hex_a, 16'h0);
    chk("rstw_led", led_a, 12'h0);
    chk("rstw_cpu", cpu_a, 16'h0);
    chk("rstw_ready", rdy_a, 1'b1);
    chk("rstw_state", dbg_a, IDLE);
    Reset = 1'b0; Mem_WE = 1'b1;
    tick(); tick();

    // READ_WAIT=2 read on instance b
    exp_q.push_back(16'h4242);
    MAR = 16'h0040; Mem_OE = 1'b0; #1;
    chk("rw2_ready_c0", rdy_b, 1'b1);
    tick();
    chk("rw2_ready_c1", rdy_b, 1'b0);
    tick();
    chk("rw2_ready_c2", rdy_b, 1'b0);
    chk("rw2_rdv_c2", rdv_b, 1'b0);
    tick();
    exp = exp_q.pop_front();
    chk("rw2_data", cpu_b, exp);
    chk("rw2_rdv_c3", rdv_b, 1'b1);
    chk("rw2_ready_c3", rdy_b, 1'b1);
    Mem_OE = 1'b1;
    tick(); tick();

    // Both strobes low on instance b: write wins, OE_N stays high
    we_s = we_low_b; oe_s = oe_low_b;
    MAR = 16'h0050; Data_from_CPU = 16'h7777; Mem_OE = 1'b0; Mem_WE = 1'b0; #1;
    chk("both_oe_n_c0", oe_n_b, 1'b1);
    tick();
    chk("both_we_n_c1", we_n_b, 1'b0);
    chk("both_oe_n_c1", oe_n_b, 1'b1);
    tick();
    Mem_OE = 1'b1; Mem_WE = 1'b1;
    tick(); tick();
    chk("both_mem", mem_b[8'h50], 16'h7777);
    chk("both_we_cycles", 32'(we_low_b - we_s), 32'd1);
    chk("both_oe_low_cycles", 32'(oe_low_b - oe_s), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
